// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: FSM state
// encoding and parity-sense constants.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Map the PARITY_ODD parameter onto the parity sense bit XORed into ^data.
    function automatic logic par_sense(input int unsigned odd);
        return (odd != 0) ? PAR_ODD : PAR_EVEN;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO buffering bytes for the UART transmitter.
// DEPTH must be a power of two so the pointers wrap naturally.
// A write while full is ignored; a simultaneous write and read keeps level.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   wr_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   rd_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [LW-1:0]    level_q;
    logic             do_wr;
    logic             do_rd;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_wr   = wr_i && !full_o;
    assign do_rd   = rd_i && !empty_o;
    assign rdata_o = mem_q[rptr_q];
    assign level_o = level_q;

    // Storage array: written at the write pointer, no reset needed.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; reset flushes the FIFO.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_wr) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_rd) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter with input FIFO, clocked at the bit rate.
// Frame: start, LSB-first data, optional parity, STOP_BITS stop bits.
// Optional feature macro: UART_TX_PARITY_EN (adds one parity bit per frame).
module uart_tx_fifo_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                        clk_div,
    input  logic                        reset,
    input  logic [DATA_BITS-1:0]        din,
    input  logic                        wr_en,
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow,
    output logic                        tx
);

    localparam int unsigned BW        = $clog2(DATA_BITS + 1);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

    state_e                 state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [BW-1:0]          bitcnt_q, bitcnt_d;
    logic                   stopcnt_q, stopcnt_d;
    logic                   tx_q, tx_d;
    logic                   overflow_q, overflow_d;
    logic [DATA_BITS-1:0]   head;
    logic                   empty;
    logic                   pop;
`ifdef UART_TX_PARITY_EN
    localparam logic        PAR_SENSE = par_sense(PARITY_ODD);
    logic                   par_q, par_d;
`endif

    param_legal_a: assert property (@(posedge clk_div)
        (DATA_BITS >= 5) && (DATA_BITS <= 9) &&
        (STOP_BITS >= 1) && (STOP_BITS <= 2) &&
        (FIFO_DEPTH >= 2) && (FIFO_DEPTH <= 16) &&
        ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0) &&
        (PARITY_ODD <= 1));

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_div),
        .reset_i (reset),
        .wr_i    (wr_en),
        .wdata_i (din),
        .rd_i    (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    // State register plus shift register, counters, line and sticky overflow.
    always_ff @(posedge clk_div) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bitcnt_q   <= '0;
            stopcnt_q  <= 1'b0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
            stopcnt_q  <= stopcnt_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    // Next-state logic; the shift register moves right so tx always takes bit 0.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bitcnt_d   = bitcnt_q;
        stopcnt_d  = stopcnt_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        overflow_d = overflow_q | (wr_en & full);
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    tx_d    = 1'b0;
                    state_d = ST_START;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^head) ^ PAR_SENSE;
`endif
                end else begin
                    tx_d = 1'b1;
                end
            end
            ST_START: begin
                tx_d     = shift_q[0];
                shift_d  = shift_q >> 1;
                bitcnt_d = BW'(1);
                state_d  = ST_DATA;
            end
            ST_DATA: begin
                if (bitcnt_q < BW'(DATA_BITS)) begin
                    tx_d     = shift_q[0];
                    shift_d  = shift_q >> 1;
                    bitcnt_d = bitcnt_q + 1'b1;
                end else begin
                    stopcnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                    tx_d      = par_q;
                    state_d   = ST_PARITY;
`else
                    tx_d      = 1'b1;
                    state_d   = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                tx_d      = 1'b1;
                stopcnt_d = 1'b0;
                state_d   = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (stopcnt_q == STOP_LAST) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        tx_d    = 1'b0;
                        state_d = ST_START;
`ifdef UART_TX_PARITY_EN
                        par_d   = (^head) ^ PAR_SENSE;
`endif
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    stopcnt_d = stopcnt_q + 1'b1;
                    tx_d      = 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_STOP) && (stopcnt_q == STOP_LAST);
    end

    assign tx       = tx_q;
    assign overflow = overflow_q;

endmodule
